// File: rtl/pe_weight_loader_pkg.sv
// Shared types and helpers for the PE weight loader: FSM state encoding,
// default PE-array geometry and the num_pe configuration mapping.
package pe_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } loader_state_t;

  localparam int PE_ADDR_WIDTH = 3;
  localparam int NUM_PE        = 1 << PE_ADDR_WIDTH;

  // A configured PE count of zero stands for the full array.
  function automatic int unsigned eff_num_pe(input int unsigned cfg, input int unsigned addr_width);
    if (cfg == 32'd0) begin
      return 32'd1 << addr_width;
    end else begin
      return cfg;
    end
  endfunction

endpackage

// File: rtl/pe_weight_loader.sv
// Weight-stream sequencer feeding the PE binary decoder: assigns each accepted
// word a PE index and depth slot (PE-fastest) and drives a registered write bus.
module pe_weight_loader
  import pe_pkg::*;
#(
  parameter int ADDR_WIDTH = PE_ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int SLOT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   cfg_num_pe,
  input  logic [SLOT_WIDTH:0]   cfg_depth,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [SLOT_WIDTH-1:0] wr_slot,
  output logic                  busy,
  output logic                  done
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int SW1 = SLOT_WIDTH + 1;

  loader_state_t         state_r, state_nxt_s;
  logic [ADDR_WIDTH:0]   num_pe_r;
  logic [SLOT_WIDTH:0]   depth_r;
  logic [ADDR_WIDTH-1:0] pe_cnt_r, pe_cnt_nxt_s;
  logic [SLOT_WIDTH-1:0] slot_cnt_r, slot_cnt_nxt_s;
  logic [ADDR_WIDTH:0]   cfg_num_pe_eff_s;
  logic                  accept_s, pe_wrap_s, last_beat_s;
  logic                  start_load_s, start_empty_s, last_accept_s;
  logic                  wr_en_r, done_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic [SLOT_WIDTH-1:0] wr_slot_r;

  assign cfg_num_pe_eff_s = AW1'(eff_num_pe(32'(cfg_num_pe), ADDR_WIDTH));

  // Abort must block the handshake in the same cycle, so ready is combinational.
  assign s_ready  = (state_r == LOAD) && !abort;
  assign accept_s = s_valid && s_ready;

  // Compares run one bit wider than the counters so num_pe-1 cannot wrap.
  assign pe_wrap_s   = ({1'b0, pe_cnt_r} == (num_pe_r - AW1'(1)));
  assign last_beat_s = pe_wrap_s && ({1'b0, slot_cnt_r} == (depth_r - SW1'(1)));

  // Next-state and counter sequencing; abort overrides start and acceptance.
  always_comb begin
    state_nxt_s    = state_r;
    pe_cnt_nxt_s   = pe_cnt_r;
    slot_cnt_nxt_s = slot_cnt_r;
    start_load_s   = 1'b0;
    start_empty_s  = 1'b0;
    last_accept_s  = 1'b0;
    if (abort) begin
      state_nxt_s    = IDLE;
      pe_cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
      slot_cnt_nxt_s = {SLOT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (cfg_depth != {SW1{1'b0}}) begin
              start_load_s   = 1'b1;
              state_nxt_s    = LOAD;
              pe_cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
              slot_cnt_nxt_s = {SLOT_WIDTH{1'b0}};
            end else begin
              start_empty_s = 1'b1;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LOAD: begin
          if (accept_s) begin
            if (last_beat_s) begin
              state_nxt_s    = IDLE;
              pe_cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
              slot_cnt_nxt_s = {SLOT_WIDTH{1'b0}};
              last_accept_s  = 1'b1;
            end else if (pe_wrap_s) begin
              pe_cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
              slot_cnt_nxt_s = slot_cnt_r + SLOT_WIDTH'(1);
            end else begin
              pe_cnt_nxt_s = pe_cnt_r + ADDR_WIDTH'(1);
            end
          end else begin
            state_nxt_s = LOAD;
          end
        end
        default: begin
          state_nxt_s    = IDLE;
          pe_cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
          slot_cnt_nxt_s = {SLOT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, configuration latch and registered write bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      num_pe_r   <= {AW1{1'b0}};
      depth_r    <= {SW1{1'b0}};
      pe_cnt_r   <= {ADDR_WIDTH{1'b0}};
      slot_cnt_r <= {SLOT_WIDTH{1'b0}};
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
      wr_data_r  <= {DATA_WIDTH{1'b0}};
      wr_slot_r  <= {SLOT_WIDTH{1'b0}};
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pe_cnt_r   <= pe_cnt_nxt_s;
      slot_cnt_r <= slot_cnt_nxt_s;
      if (start_load_s) begin
        num_pe_r <= cfg_num_pe_eff_s;
        depth_r  <= cfg_depth;
      end
      wr_en_r <= accept_s;
      if (accept_s) begin
        wr_addr_r <= pe_cnt_r;
        wr_data_r <= s_data;
        wr_slot_r <= slot_cnt_r;
      end
      done_r <= last_accept_s || start_empty_s;
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign wr_slot = wr_slot_r;
  assign busy    = (state_r == LOAD);
  assign done    = done_r;

endmodule

// File: tb/tb_pe_weight_loader.sv
// Directed self-checking bench for pe_weight_loader: a monitor logs every write
// and done pulse; each scenario compares the log against hand-derived values.
module tb_pe_weight_loader;

  logic       clk = 1'b0;
  logic       rst, start, abort, s_valid, s_ready;
  logic [3:0] cfg_num_pe;
  logic [4:0] cfg_depth;
  logic [7:0] s_data, wr_data;
  logic       wr_en, busy, done;
  logic [2:0] wr_addr;
  logic [3:0] wr_slot;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wq_addr[$], wq_slot[$], wq_data[$], wq_cyc[$], wq_busy[$];
  int dq_cyc[$], dq_busy[$];

  pe_weight_loader #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .SLOT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_pe(cfg_num_pe), .cfg_depth(cfg_depth),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_slot(wr_slot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Log the write bus and done pulses 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      wq_addr.push_back(int'(wr_addr));
      wq_slot.push_back(int'(wr_slot));
      wq_data.push_back(int'(wr_data));
      wq_cyc.push_back(cyc);
      wq_busy.push_back(int'(busy));
    end
    if (done === 1'b1) begin
      dq_cyc.push_back(cyc);
      dq_busy.push_back(int'(busy));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    wq_addr.delete(); wq_slot.delete(); wq_data.delete();
    wq_cyc.delete(); wq_busy.delete(); dq_cyc.delete(); dq_busy.delete();
  endtask

  task automatic do_start(input logic [3:0] np, input logic [4:0] d);
    start = 1'b1; cfg_num_pe = np; cfg_depth = d;
    tick();
    start = 1'b0;
  endtask

  // Present words first..first+n-1, advancing only on a handshake.
  task automatic stream(input int first, input int n, input bit gap);
    int   idx;
    logic acc;
    idx = first;
    for (int c = 0; c < 200 && idx < first + n; c++) begin
      s_valid = gap ? (c % 2 == 0) : 1'b1;
      s_data  = 8'(idx);
      @(negedge clk);
      acc = s_valid && s_ready;
      tick();
      if (acc) idx++;
    end
    s_valid = 1'b0;
    chk("stream_words", idx, first + n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b1;
    s_data = 8'd0; cfg_num_pe = 4'd0; cfg_depth = 5'd0;

    // Reset with valid held high.
    tick(); tick();
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_no_write", wq_addr.size(), 0);
    s_valid = 1'b0;
    clear_log();

    // Full 8x2 load, continuous valid.
    do_start(4'd0, 5'd2);
    stream(0, 16, 1'b0);
    tick(); tick();
    chk("full_writes", wq_addr.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk("full_addr", wq_addr[k], k % 8);
      chk("full_slot", wq_slot[k], k / 8);
      chk("full_data", wq_data[k], k);
    end
    chk("full_w9_addr", wq_addr[9], 1);
    chk("full_w9_slot", wq_slot[9], 1);
    chk("full_busy_mid", wq_busy[0], 1);
    chk("full_done_cnt", dq_cyc.size(), 1);
    chk("full_done_cyc", dq_cyc[0], wq_cyc[15]);
    chk("full_done_busy", dq_busy[0], 0);
    chk("full_consec", wq_cyc[15] - wq_cyc[0], 15);
    clear_log();

    // Zero depth: done one cycle after start, no writes, never busy.
    begin
      int c0;
      c0 = cyc;
      s_valid = 1'b1;
      do_start(4'd3, 5'd0);
      chk("zero_busy", busy, 1'b0);
      tick(); tick();
      s_valid = 1'b0;
      chk("zero_writes", wq_addr.size(), 0);
      chk("zero_done_cnt", dq_cyc.size(), 1);
      chk("zero_done_cyc", dq_cyc[0], c0 + 1);
      chk("zero_done_busy", dq_busy[0], 0);
    end
    clear_log();

    // Abort after 5 beats of 8x2, with an ignored start mid-load.
    do_start(4'd8, 5'd2);
    stream(0, 2, 1'b0);
    start = 1'b1; cfg_num_pe = 4'd3; cfg_depth = 5'd1;
    s_valid = 1'b1; s_data = 8'd2;
    tick();
    start = 1'b0;
    stream(3, 2, 1'b0);
    abort = 1'b1; s_valid = 1'b1; s_data = 8'd5;
    #1;
    chk("abort_ready", s_ready, 1'b0);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    tick(); tick(); tick();
    chk("abort_writes", wq_addr.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("abort_addr", wq_addr[k], k);
      chk("abort_slot", wq_slot[k], 0);
      chk("abort_data", wq_data[k], k);
    end
    chk("abort_no_done", dq_cyc.size(), 0);
    chk("abort_busy", busy, 1'b0);
    clear_log();

    // Fresh 3x3 load with valid toggling.
    do_start(4'd3, 5'd3);
    stream(0, 9, 1'b1);
    tick(); tick();
    chk("part_writes", wq_addr.size(), 9);
    for (int k = 0; k < 9; k++) begin
      chk("part_addr", wq_addr[k], k % 3);
      chk("part_slot", wq_slot[k], k / 3);
      chk("part_data", wq_data[k], k);
    end
    for (int k = 1; k < 9; k++) chk("part_gap", wq_cyc[k] - wq_cyc[k-1], 2);
    chk("part_done_cnt", dq_cyc.size(), 1);
    chk("part_done_cyc", dq_cyc[0], wq_cyc[8]);
    clear_log();

    // Reset after beat 4 of a load, then a short clean load.
    do_start(4'd0, 5'd2);
    stream(0, 4, 1'b0);
    rst = 1'b1;
    tick();
    chk("mrst_wr_en", wr_en, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_ready", s_ready, 1'b0);
    chk("mrst_wr_addr", wr_addr, 3'd0);
    rst = 1'b0;
    tick(); tick();
    chk("mrst_writes", wq_addr.size(), 4);
    chk("mrst_no_done", dq_cyc.size(), 0);
    clear_log();
    do_start(4'd2, 5'd1);
    stream(0, 2, 1'b0);
    tick(); tick();
    chk("post_writes", wq_addr.size(), 2);
    chk("post_addr0", wq_addr[0], 0);
    chk("post_addr1", wq_addr[1], 1);
    chk("post_slot1", wq_slot[1], 0);
    chk("post_data1", wq_data[1], 1);
    chk("post_done_cnt", dq_cyc.size(), 1);
    chk("post_done_cyc", dq_cyc[0], wq_cyc[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
